apb_cmd_master: RTL and testbench

//  Upstream APB requester for the UART register slave (CTRL 0x00, STATS 0x04, TX 0x08, RX 0x0C).

---
 rtl/apb_cmd_master.sv | 106 ++++++++++
 tb/tb_apb_cmd_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB requester: turns one valid/ready command into one SETUP+ACCESS transfer
// and returns read data or a PREADY-timeout error on a valid/ready response.
module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LIM =
      (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          tmo;

   assign cmd_ready = (state == IDLE);
   assign PSEL      = (state == SETUP) || (state == ACCESS);
   assign PENABLE   = (state == ACCESS);
   assign rsp_valid = (state == RESP);
   assign accept    = cmd_valid & cmd_ready;

   // TIMEOUT=0 disables the abort path entirely
   always_comb begin
      tmo = 1'b0;
      if (TIMEOUT != 0)
         tmo = !PREADY && (cnt == LIM);
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (accept) state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: if (PREADY || tmo) state_nxt = RESP;
         RESP:   if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            cnt    <= '0;
         end
         // PREADY takes priority over a coincident timeout
         if (state == ACCESS) begin
            if (PREADY) begin
               rsp_rdata <= PWRITE ? '0 : PRDATA;
               rsp_err   <= 1'b0;
            end else if (tmo) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end else if (cnt != '1) begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master against a small UART-like APB slave model
// with configurable wait states and a hang mode.
module tb_apb_cmd_master;

   logic        PCLK;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // slave model
   logic [31:0] ctrl_r;
   logic [31:0] stats_r;
   logic [31:0] tx_r;
   int          waits;
   bit          hang;
   int          wcnt;

   assign PREADY = PSEL && PENABLE && !hang && (wcnt >= waits);

   always_comb begin
      PRDATA = 32'hDEADBEEF;
      case (PADDR)
         32'h00: PRDATA = ctrl_r;
         32'h04: PRDATA = stats_r;
         32'h08: PRDATA = tx_r;
         32'h0C: PRDATA = 32'h0;
         default: PRDATA = 32'hDEADBEEF;
      endcase
   end

   always @(posedge PCLK) begin
      if (PRESET) begin
         wcnt <= 0;
      end else if (PSEL && PENABLE) begin
         if (PREADY) begin
            wcnt <= 0;
            if (PWRITE) begin
               case (PADDR)
                  32'h00: ctrl_r <= PWDATA;
                  32'h08: begin
                     tx_r       <= PWDATA;
                     stats_r[1] <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   int n_chk;
   int n_pass;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // one command; hold = cycles to keep rsp_ready low once rsp_valid is seen
   task automatic do_cmd(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int hold,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int su_n,
                         output int ac_n);
      logic [31:0] held;
      lat  = 0;
      su_n = 0;
      ac_n = 0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      rsp_ready = 1'b0;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (rsp_valid) begin
            lat = cyc;
            break;
         end
         if (PSEL && !PENABLE) su_n++;
         if (PSEL && PENABLE) begin
            ac_n++;
            if (ac_n == 1) begin
               chk("paddr", PADDR, a);
               chk("pwrite", PWRITE, 32'(wr));
               chk("pwdata", PWDATA, d);
            end
         end
         @(negedge PCLK);
      end
      chk("rsp_seen", rsp_valid, 1);
      held = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_addr  = 32'h0C;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, held);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_psel", PSEL, 0);
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("back_idle", cmd_ready, 1);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          su;
   int          ac;

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      ctrl_r    = 0;
      stats_r   = 0;
      tx_r      = 0;
      waits     = 1;
      hang      = 0;
      cmd_valid = 0;
      cmd_write = 0;
      cmd_addr  = 0;
      cmd_wdata = 0;
      rsp_ready = 0;
      PRESET    = 1'b1;
      #12;
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_rdata", rsp_rdata, 0);
      @(negedge PCLK);
      PRESET = 1'b0;

      // write CTRL through a one-wait-state slave
      do_cmd(1, 32'h00, 32'h5, 0, rd, er, lat, su, ac);
      chk("wr_setup_n", su, 1);
      chk("wr_access_n", ac, 2);
      chk("wr_err", er, 0);
      chk("wr_rdata", rd, 0);
      chk("wr_lat", lat, 4);
      chk("slave_ctrl", ctrl_r, 32'h5);

      do_cmd(1, 32'h08, 32'hA5, 0, rd, er, lat, su, ac);
      chk("tx_wr_err", er, 0);

      // read STATS with the response held off for 5 cycles
      do_cmd(0, 32'h04, 32'h0, 5, rd, er, lat, su, ac);
      chk("stats_txdone", rd & 32'h2, 32'h2);
      chk("stats_err", er, 0);
      chk("stats_lat", lat, 4);
      chk("no_extra_setup", PSEL, 0);

      do_cmd(0, 32'h08, 32'h0, 0, rd, er, lat, su, ac);
      chk("tx_rd", rd, 32'hA5);

      do_cmd(0, 32'h10, 32'h0, 0, rd, er, lat, su, ac);
      chk("unmapped_rd", rd, 32'hDEADBEEF);
      chk("unmapped_err", er, 0);

      // zero-wait slave
      waits = 0;
      do_cmd(0, 32'h00, 32'h0, 0, rd, er, lat, su, ac);
      chk("zw_lat", lat, 3);
      chk("zw_access_n", ac, 1);
      chk("zw_rdata", rd, 32'h5);

      // PREADY arrives exactly at the timeout limit: must win
      waits = 15;
      do_cmd(0, 32'h00, 32'h0, 0, rd, er, lat, su, ac);
      chk("lim_access_n", ac, 16);
      chk("lim_err", er, 0);
      chk("lim_rdata", rd, 32'h5);

      // hung slave
      hang = 1;
      do_cmd(0, 32'h00, 32'h0, 0, rd, er, lat, su, ac);
      chk("to_access_n", ac, 16);
      chk("to_lat", lat, 18);
      chk("to_err", er, 1);
      chk("to_rdata", rd, 0);

      // reset in the middle of ACCESS
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h04;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      for (int i = 0; i < 10 && !PENABLE; i++)
         @(negedge PCLK);
      chk("pre_rst_penable", PENABLE, 1);
      PRESET = 1'b1;
      #1;
      chk("mid_rst_psel", PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_paddr", PADDR, 0);
      @(negedge PCLK);
      PRESET = 1'b0;
      hang   = 0;
      waits  = 1;
      @(negedge PCLK);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_rsp_valid", rsp_valid, 0);

      do_cmd(0, 32'h08, 32'h0, 0, rd, er, lat, su, ac);
      chk("post_rst_rd", rd, 32'hA5);
      chk("post_rst_lat", lat, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
